// File: rtl/uart_rx_byte.sv
// Purpose:      8N1 UART byte receiver; 2-flop synchronised rxd, mid-bit sampling,
//               glitch-start rejection and framing-error detection.
// Latency:      done/error pulse 2+HALF_CNT+9*BIT_CNT+1 clocks after rxd falls.
// Backpressure: none; each byte is presented for one cycle and must be taken then.
// Ports:
//   clk_50m        in   system clock
//   rst            in   synchronous reset, active-high
//   uart_rxd       in   asynchronous serial line, idles high
//   uart_rx_data   out  [7:0] last good byte, held until the next good byte
//   uart_rx_done   out  one-cycle strobe, uart_rx_data valid in the same cycle
//   uart_rx_busy   out  high while a frame is in progress
//   uart_frame_err out  one-cycle strobe when the stop bit is sampled low
module uart_rx_byte #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_rx_busy,
  output logic       uart_frame_err
);

  // BIT_CNT must be at least 4 for the half-bit offset to be meaningful.
  localparam int BIT_CNT  = CLK_FREQ / BAUD;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CNT_W    = $clog2(BIT_CNT);

  // The counter reads k-1 in the k-th cycle after it was cleared, so a
  // sample k clocks after the clear happens when it equals k-1.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_rx_data;
  logic             r_done;
  logic             r_err;
  logic             r_rx_s1;
  logic             r_rx_sync;
  logic             r_rx_prev;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_clk_cnt_nxt;
  logic [2:0]       w_bit_cnt_nxt;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_rx_data_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_start_edge;
  logic             w_bit_last;
  logic             w_half_last;

  // Synchroniser and edge-history flops. Clearing them to 0 means a line
  // held low through reset never looks like a falling edge.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_rx_s1   <= 1'b0;
      r_rx_sync <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_rx_s1   <= uart_rxd;
      r_rx_sync <= r_rx_s1;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_start_edge = r_rx_prev & ~r_rx_sync;
  assign w_bit_last   = (r_clk_cnt == BIT_LAST);
  assign w_half_last  = (r_clk_cnt == HALF_LAST);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_rx_data <= w_rx_data_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt + CNT_W'(1);
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_rx_data_nxt = r_rx_data;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Counter parked at 0; it starts counting the cycle after the edge.
        w_clk_cnt_nxt = '0;
        if (w_start_edge) begin
          w_state_nxt = ST_START;
        end
      end

      ST_START: begin
        if (w_half_last) begin
          w_clk_cnt_nxt = '0;
          // A line already back high at mid-start-bit was only a glitch.
          w_state_nxt   = r_rx_sync ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (w_bit_last) begin
          w_clk_cnt_nxt = '0;
          // LSB arrives first, so shift in at the top and move right.
          w_shift_nxt   = {r_rx_sync, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (w_bit_last) begin
          w_clk_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
          if (r_rx_sync) begin
            w_rx_data_nxt = r_shift;
            w_done_nxt    = 1'b1;
          end else begin
            w_err_nxt     = 1'b1;
          end
        end
      end

      default: begin
        w_clk_cnt_nxt = '0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  assign uart_rx_data   = r_rx_data;
  assign uart_rx_done   = r_done;
  assign uart_frame_err = r_err;
  // Busy drops in the same cycle the done/error strobe is visible.
  assign uart_rx_busy   = (r_state != ST_IDLE);

endmodule
